soda_vend_ctrl: RTL and testbench

SODA_VEND_CTRL -- requirements
Module: soda_vend_ctrl

---
 rtl/soda_vend_ctrl.sv | 104 ++++++++++
 tb/tb_soda_vend_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soda_vend_ctrl.sv
// Soda vending controller: collects nickel/dime/quarter credit, vends at PRICE,
// and returns change greedily, one coin per cycle.
module soda_vend_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRICE = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_n,
    input  logic             coin_d,
    input  logic             coin_q,
    input  logic             cancel,
    input  logic             sold_out,
    output logic             dispense,
    output logic             ret_n,
    output logic             ret_d,
    output logic             ret_q,
    output logic             reject,
    output logic [WIDTH-1:0] credit,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [WIDTH-1:0] P   = WIDTH'(PRICE);
    localparam logic [WIDTH-1:0] C5  = WIDTH'(5);
    localparam logic [WIDTH-1:0] C10 = WIDTH'(10);
    localparam logic [WIDTH-1:0] C25 = WIDTH'(25);

    state_t           state, state_nx;
    logic [WIDTH-1:0] credit_r, credit_nx;
    logic             reject_r, reject_nx;
    logic [2:0]       coins;
    logic             one_coin, any_coin, accept;
    logic [WIDTH-1:0] coin_val, chg_val;

    assign coins    = {coin_q, coin_d, coin_n};
    assign any_coin = |coins;
    assign one_coin = (coins == 3'b001) || (coins == 3'b010) || (coins == 3'b100);

    always_comb begin
        coin_val = C5;
        if (coin_q)      coin_val = C25;
        else if (coin_d) coin_val = C10;
    end

    // Greedy change coin for the current CHANGE cycle; also drives the strobes.
    always_comb begin
        chg_val = C5;
        if (credit_r >= C25)      chg_val = C25;
        else if (credit_r >= C10) chg_val = C10;
    end

    always_comb begin
        state_nx  = state;
        credit_nx = credit_r;
        accept    = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (state == COLLECT && (cancel || sold_out)) begin
                    state_nx = CHANGE;
                end else if (state == COLLECT && credit_r >= P) begin
                    state_nx = VEND;
                end else if (one_coin && !cancel && !sold_out && credit_r < P) begin
                    accept    = 1'b1;
                    credit_nx = credit_r + coin_val;
                    state_nx  = COLLECT;
                end
            end
            VEND: begin
                credit_nx = credit_r - P;
                state_nx  = (credit_nx != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                credit_nx = credit_r - chg_val;
                if (credit_nx == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        reject_nx = any_coin && !accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            credit_r <= '0;
            reject_r <= 1'b0;
        end else begin
            state    <= state_nx;
            credit_r <= credit_nx;
            reject_r <= reject_nx;
        end
    end

    // All outputs come from state/credit/reject registers only.
    assign dispense = (state == VEND);
    assign ret_q    = (state == CHANGE) && (chg_val == C25);
    assign ret_d    = (state == CHANGE) && (chg_val == C10);
    assign ret_n    = (state == CHANGE) && (chg_val == C5);
    assign reject   = reject_r;
    assign credit   = credit_r;
    assign busy     = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_soda_vend_ctrl.sv
// Directed bench for soda_vend_ctrl: table-driven steps with hand-computed outputs.
module tb_soda_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0;
    logic       cancel = 1'b0, sold_out = 1'b0;
    logic       dispense, ret_n, ret_d, ret_q, reject, busy;
    logic [7:0] credit;

    int n_checks = 0;
    int n_fail   = 0;

    // coins = {q,d,n}; o = {dispense,ret_q,ret_d,ret_n,reject,busy}
    typedef struct packed {
        logic [2:0] coins;
        logic       cncl;
        logic       sold;
        logic [5:0] o;
        logic [7:0] cr;
    } step_t;

    soda_vend_ctrl #(.WIDTH(8), .PRICE(100)) dut (
        .clk(clk), .rst(rst),
        .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q),
        .cancel(cancel), .sold_out(sold_out),
        .dispense(dispense), .ret_n(ret_n), .ret_d(ret_d), .ret_q(ret_q),
        .reject(reject), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== 6'b0 || credit !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: strobes %b credit %0d, want 000000 / 0",
                     {dispense, ret_q, ret_d, ret_n, reject, busy}, credit);
        end
        rst = 1'b0;
    endtask

    task automatic test_exact_price();
        step_t st[6] = '{
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd25},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd50},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd75},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd100},
            '{3'b001, 1'b0, 1'b0, 6'b100011, 8'd100},  // coin at credit>=PRICE rejected
            '{3'b000, 1'b0, 1'b0, 6'b000000, 8'd0}
        };
        for (int i = 0; i < 6; i++) begin
            {coin_q, coin_d, coin_n} = st[i].coins; cancel = st[i].cncl; sold_out = st[i].sold;
            tick();
            {coin_q, coin_d, coin_n} = 3'b0; cancel = 1'b0; sold_out = 1'b0;
            n_checks++;
            if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== st[i].o) begin
                n_fail++;
                $display("FAIL exact step %0d strobes got %b want %b", i,
                         {dispense, ret_q, ret_d, ret_n, reject, busy}, st[i].o);
            end
            n_checks++;
            if (credit !== st[i].cr) begin
                n_fail++;
                $display("FAIL exact step %0d credit got %0d want %0d", i, credit, st[i].cr);
            end
        end
    endtask

    task automatic test_change();
        step_t st[10] = '{
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd25},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd50},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd75},
            '{3'b010, 1'b0, 1'b0, 6'b000000, 8'd85},
            '{3'b001, 1'b0, 1'b0, 6'b000000, 8'd90},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd115},
            '{3'b000, 1'b0, 1'b0, 6'b100001, 8'd115},
            '{3'b000, 1'b0, 1'b0, 6'b001001, 8'd15},
            '{3'b000, 1'b0, 1'b0, 6'b000101, 8'd5},
            '{3'b000, 1'b0, 1'b0, 6'b000000, 8'd0}
        };
        for (int i = 0; i < 10; i++) begin
            {coin_q, coin_d, coin_n} = st[i].coins; cancel = st[i].cncl; sold_out = st[i].sold;
            tick();
            {coin_q, coin_d, coin_n} = 3'b0; cancel = 1'b0; sold_out = 1'b0;
            n_checks++;
            if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== st[i].o) begin
                n_fail++;
                $display("FAIL change step %0d strobes got %b want %b", i,
                         {dispense, ret_q, ret_d, ret_n, reject, busy}, st[i].o);
            end
            n_checks++;
            if (credit !== st[i].cr) begin
                n_fail++;
                $display("FAIL change step %0d credit got %0d want %0d", i, credit, st[i].cr);
            end
        end
    endtask

    task automatic test_cancel();
        step_t st[5] = '{
            '{3'b010, 1'b0, 1'b0, 6'b000000, 8'd10},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd35},
            '{3'b001, 1'b1, 1'b0, 6'b010011, 8'd35},
            '{3'b000, 1'b1, 1'b0, 6'b001001, 8'd10},  // cancel ignored in CHANGE
            '{3'b000, 1'b0, 1'b0, 6'b000000, 8'd0}
        };
        for (int i = 0; i < 5; i++) begin
            {coin_q, coin_d, coin_n} = st[i].coins; cancel = st[i].cncl; sold_out = st[i].sold;
            tick();
            {coin_q, coin_d, coin_n} = 3'b0; cancel = 1'b0; sold_out = 1'b0;
            n_checks++;
            if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== st[i].o) begin
                n_fail++;
                $display("FAIL cancel step %0d strobes got %b want %b", i,
                         {dispense, ret_q, ret_d, ret_n, reject, busy}, st[i].o);
            end
            n_checks++;
            if (credit !== st[i].cr) begin
                n_fail++;
                $display("FAIL cancel step %0d credit got %0d want %0d", i, credit, st[i].cr);
            end
        end
    endtask

    task automatic test_collision();
        step_t st[10] = '{
            '{3'b011, 1'b0, 1'b0, 6'b000010, 8'd0},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd25},
            '{3'b101, 1'b0, 1'b0, 6'b000010, 8'd25},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd50},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd75},
            '{3'b010, 1'b0, 1'b0, 6'b000000, 8'd85},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd110},
            '{3'b000, 1'b0, 1'b0, 6'b100001, 8'd110},
            '{3'b100, 1'b0, 1'b0, 6'b001011, 8'd10},
            '{3'b100, 1'b0, 1'b0, 6'b000010, 8'd0}
        };
        for (int i = 0; i < 10; i++) begin
            {coin_q, coin_d, coin_n} = st[i].coins; cancel = st[i].cncl; sold_out = st[i].sold;
            tick();
            {coin_q, coin_d, coin_n} = 3'b0; cancel = 1'b0; sold_out = 1'b0;
            n_checks++;
            if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== st[i].o) begin
                n_fail++;
                $display("FAIL collision step %0d strobes got %b want %b", i,
                         {dispense, ret_q, ret_d, ret_n, reject, busy}, st[i].o);
            end
            n_checks++;
            if (credit !== st[i].cr) begin
                n_fail++;
                $display("FAIL collision step %0d credit got %0d want %0d", i, credit, st[i].cr);
            end
        end
        tick();
        n_checks++;
        if (reject !== 1'b0) begin
            n_fail++;
            $display("FAIL collision reject width got %b want 0", reject);
        end
    endtask

    task automatic test_sold_out();
        step_t st[9] = '{
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd25},
            '{3'b100, 1'b0, 1'b0, 6'b000000, 8'd50},
            '{3'b010, 1'b0, 1'b0, 6'b000000, 8'd60},
            '{3'b001, 1'b0, 1'b1, 6'b010011, 8'd60},
            '{3'b010, 1'b0, 1'b1, 6'b010011, 8'd35},
            '{3'b000, 1'b0, 1'b1, 6'b001001, 8'd10},
            '{3'b000, 1'b0, 1'b1, 6'b000000, 8'd0},
            '{3'b001, 1'b0, 1'b1, 6'b000010, 8'd0},
            '{3'b000, 1'b0, 1'b0, 6'b000000, 8'd0}
        };
        for (int i = 0; i < 9; i++) begin
            {coin_q, coin_d, coin_n} = st[i].coins; cancel = st[i].cncl; sold_out = st[i].sold;
            tick();
            {coin_q, coin_d, coin_n} = 3'b0; cancel = 1'b0; sold_out = 1'b0;
            n_checks++;
            if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== st[i].o) begin
                n_fail++;
                $display("FAIL sold_out step %0d strobes got %b want %b", i,
                         {dispense, ret_q, ret_d, ret_n, reject, busy}, st[i].o);
            end
            n_checks++;
            if (credit !== st[i].cr) begin
                n_fail++;
                $display("FAIL sold_out step %0d credit got %0d want %0d", i, credit, st[i].cr);
            end
        end
    endtask

    task automatic test_reset_mid_change();
        for (int i = 0; i < 3; i++) begin
            coin_q = 1'b1;
            tick();
        end
        coin_q = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_checks++;
        if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== 6'b010001 || credit !== 8'd75) begin
            n_fail++;
            $display("FAIL midrst setup: strobes %b credit %0d, want 010001 / 75",
                     {dispense, ret_q, ret_d, ret_n, reject, busy}, credit);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== 6'b0 || credit !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst async: strobes %b credit %0d, want 000000 / 0",
                     {dispense, ret_q, ret_d, ret_n, reject, busy}, credit);
        end
        rst = 1'b0;
        coin_n = 1'b1;
        tick();
        coin_n = 1'b0;
        n_checks++;
        if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== 6'b0 || credit !== 8'd5) begin
            n_fail++;
            $display("FAIL midrst recover: strobes %b credit %0d, want 000000 / 5",
                     {dispense, ret_q, ret_d, ret_n, reject, busy}, credit);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_checks++;
        if ({dispense, ret_q, ret_d, ret_n, reject, busy} !== 6'b000101) begin
            n_fail++;
            $display("FAIL midrst refund: strobes %b, want 000101",
                     {dispense, ret_q, ret_d, ret_n, reject, busy});
        end
        tick();
    endtask

    initial begin
        test_reset();
        tick();
        test_exact_price();
        test_change();
        test_cancel();
        test_collision();
        test_sold_out();
        test_reset_mid_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
